// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and defaults for the push-button press classifier.
//   state_t   : per-channel classifier state
//   DEF_*     : default debounce / long-press / double-click window lengths
//   cnt_w()   : bit width needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        GAP      = 2'd2,
        PRESSED2 = 2'd3
    } state_t;

    localparam int DEF_DEB_CYC  = 16;
    localparam int DEF_LONG_CYC = 3072;
    localparam int DEF_GAP_CYC  = 1024;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_press_classifier_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// One button channel: 2-flop synchroniser, debouncer, press-duration counter
// and the short/long (optionally double-click) classifier FSM.
// Optional feature macro: BTN_DOUBLE_EN (adds GAP / PRESSED2 states).
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   btn         in   raw button level, asynchronous to clk
//   db          out  debounced level
//   short_pulse out  1-cycle pulse, short press completed
//   long_pulse  out  1-cycle pulse, long press completed
//   dbl_pulse   out  1-cycle pulse, double click completed (0 when disabled)
// -----------------------------------------------------------------------------
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic db,
    output logic short_pulse,
    output logic long_pulse,
    output logic dbl_pulse
);

    localparam int DW = cnt_w(DEB_CYC);
    localparam int PW = cnt_w(LONG_CYC);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [PW-1:0] LONG_MAX = PW'(LONG_CYC);

    if (DEB_CYC < 1 || LONG_CYC < 2 || GAP_CYC < 1) begin : g_param_check
        $error("btn_channel: illegal DEB_CYC/LONG_CYC/GAP_CYC");
    end

    logic          s1;
    logic          s2;
    logic [DW-1:0] deb_cnt;
    logic [PW-1:0] press_cnt;
    logic          db_rise;
    logic          is_long;
    state_t        state;
    state_t        state_nxt;
    logic          short_nxt;
    logic          long_nxt;

    // db is about to go high on this edge: counter expired while s2 is high
    assign db_rise = s2 && !db && (deb_cnt == DEB_LAST);
    assign is_long = (press_cnt >= LONG_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debounce: db follows s2 only after DEB_CYC consecutive differing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db      <= 1'b0;
            deb_cnt <= '0;
        end else if (s2 == db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            db      <= s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Counts cycles with db high; cleared on the edge db rises so that, on the
    // edge db falls, it holds exactly the number of high cycles (saturated).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_cnt <= '0;
        end else if (db_rise) begin
            press_cnt <= '0;
        end else if (db && (press_cnt != LONG_MAX)) begin
            press_cnt <= press_cnt + 1'b1;
        end
    end

`ifdef BTN_DOUBLE_EN
    localparam int GW = cnt_w(GAP_CYC);

    logic [GW-1:0] gap_cnt;
    logic          gap_done;
    logic          dbl_nxt;

    // gap_cnt = db-low cycles since the release; the release cycle itself
    // (still in PRESSED) is the first one, so expiry lands GAP_CYC cycles
    // after db fell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if ((state == PRESSED && !db) || state == GAP) begin
            if (gap_cnt != GW'(GAP_CYC)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end else begin
            gap_cnt <= '0;
        end
    end

    assign gap_done = (int'(gap_cnt) + 1) >= GAP_CYC;
`endif

    always_comb begin
        state_nxt = state;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
`ifdef BTN_DOUBLE_EN
        dbl_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (db) begin
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (!db) begin
                    if (is_long) begin
                        long_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
`ifdef BTN_DOUBLE_EN
                        state_nxt = GAP;
`else
                        short_nxt = 1'b1;
                        state_nxt = IDLE;
`endif
                    end
                end
            end
`ifdef BTN_DOUBLE_EN
            GAP: begin
                // a rise in the expiry cycle still counts as the second press
                if (db) begin
                    state_nxt = PRESSED2;
                end else if (gap_done) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PRESSED2: begin
                if (!db) begin
                    dbl_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            state       <= state_nxt;
            short_pulse <= short_nxt;
            long_pulse  <= long_nxt;
        end
    end

`ifdef BTN_DOUBLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbl_pulse <= 1'b0;
        end else begin
            dbl_pulse <= dbl_nxt;
        end
    end
`else
    assign dbl_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_press_classifier.sv
// -----------------------------------------------------------------------------
// btn_press_classifier
// Multi-channel push-button front end: per channel it synchronises, debounces
// and classifies each completed press as short or long, emitting 1-cycle
// pulses. Optional feature macro: BTN_DOUBLE_EN (double-click detection).
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   btn_i    in   [CH] raw button levels, active-high, asynchronous
//   db_o     out  [CH] debounced levels
//   short_o  out  [CH] short press completed pulses
//   long_o   out  [CH] long press completed pulses
//   dbl_o    out  [CH] double click completed pulses (0 when disabled)
// -----------------------------------------------------------------------------
module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int CH       = 4,
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] btn_i,
    output logic [CH-1:0] db_o,
    output logic [CH-1:0] short_o,
    output logic [CH-1:0] long_o,
    output logic [CH-1:0] dbl_o
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        btn_channel #(
            .DEB_CYC  (DEB_CYC),
            .LONG_CYC (LONG_CYC),
            .GAP_CYC  (GAP_CYC)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn         (btn_i[i]),
            .db          (db_o[i]),
            .short_pulse (short_o[i]),
            .long_pulse  (long_o[i]),
            .dbl_pulse   (dbl_o[i])
        );
    end

endmodule
